// File: rtl/trig_conditioner.sv
// Trigger input conditioner: synchronizer, debounce FSM, holdoff lockout and
// accepted/dropped trigger counters.
module trig_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       enable,
    output logic       level,
    output logic       trig_pulse,
    output logic       busy,
    output logic [7:0] trig_count,
    output logic [7:0] drop_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);

    // Entry into a CHK state already consumes one differing cycle, so the
    // counter only has to cover the remaining DEBOUNCE_CYCLES-1.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] ST_LOW      = 2'd0;
    localparam logic [1:0] ST_RISE_CHK = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_FALL_CHK = 2'd3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_db_state;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_ho_state;
    logic [HO_W-1:0]        r_ho_cnt;
    logic                   r_trig;
    logic [7:0]             r_trig_count;
    logic [7:0]             r_drop_count;

    logic                   w_sync_in;
    logic [1:0]             w_db_state_nxt;
    logic [DB_W-1:0]        w_db_cnt_nxt;
    logic                   w_rise_evt;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_db_state_nxt = r_db_state;
        w_db_cnt_nxt   = r_db_cnt;
        w_rise_evt     = 1'b0;
        case (r_db_state)
            ST_LOW: begin
                if (w_sync_in) begin
                    w_db_state_nxt = ST_RISE_CHK;
                    w_db_cnt_nxt   = '0;
                end
            end
            ST_RISE_CHK: begin
                if (!w_sync_in) begin
                    w_db_state_nxt = ST_LOW;
                    w_db_cnt_nxt   = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_state_nxt = ST_HIGH;
                    w_db_cnt_nxt   = '0;
                    w_rise_evt     = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            ST_HIGH: begin
                if (!w_sync_in) begin
                    w_db_state_nxt = ST_FALL_CHK;
                    w_db_cnt_nxt   = '0;
                end
            end
            ST_FALL_CHK: begin
                if (w_sync_in) begin
                    w_db_state_nxt = ST_HIGH;
                    w_db_cnt_nxt   = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_state_nxt = ST_LOW;
                    w_db_cnt_nxt   = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_db_state_nxt = ST_LOW;
                w_db_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_state <= ST_LOW;
            r_db_cnt   <= '0;
        end else begin
            r_db_state <= w_db_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
        end
    end

    // A rise landing in the final HOLD cycle still sees busy=1 and is dropped.
    assign w_busy   = (r_ho_state == ST_HOLD);
    assign w_accept = w_rise_evt && enable && !w_busy;
    assign w_drop   = w_rise_evt && w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ho_state   <= ST_IDLE;
            r_ho_cnt     <= '0;
            r_trig       <= 1'b0;
            r_trig_count <= 8'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_trig <= w_accept;
            if (w_accept) begin
                r_trig_count <= r_trig_count + 8'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            case (r_ho_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ho_state <= ST_HOLD;
                        r_ho_cnt   <= '0;
                    end
                end
                default: begin
                    if (r_ho_cnt == HO_LAST) begin
                        r_ho_state <= ST_IDLE;
                        r_ho_cnt   <= '0;
                    end else begin
                        r_ho_cnt <= r_ho_cnt + HO_W'(1);
                    end
                end
            endcase
        end
    end

    assign level      = (r_db_state == ST_HIGH) || (r_db_state == ST_FALL_CHK);
    assign trig_pulse = r_trig;
    assign busy       = w_busy;
    assign trig_count = r_trig_count;
    assign drop_count = r_drop_count;

endmodule

// File: doc/trig_conditioner.md
TRIG_CONDITIONER -- requirements
Module: trig_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count (legal: >=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a level change (legal: >=2).
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 32, lockout length after an accepted trigger (legal: >=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port btn_in  input  1  asynchronous raw trigger source (button or external line), may bounce.
REQ-007 SHALL have port enable  input  1  trigger qualify; 0 suppresses trig_pulse generation.
REQ-008 SHALL have port level  output  1  debounced level of btn_in.
REQ-009 SHALL have port trig_pulse  output  1  one-cycle accepted-trigger strobe; drives en of the downstream pulse-stretch counter stage.
REQ-010 SHALL have port busy  output  1  high while the holdoff window is active.
REQ-011 SHALL have port trig_count  output  8  accepted trigger count.
REQ-012 SHALL have port drop_count  output  8  rising edges rejected because busy was high.

Function
REQ-013 SHALL pass btn_in through a SYNC_STAGES-deep flop chain; the last stage is sync_in; no other logic SHALL read btn_in.
REQ-014 SHALL implement a debounce FSM: LOW, RISE_CHK, HIGH, FALL_CHK; level=1 in HIGH and FALL_CHK, else 0.
REQ-015 LOW->RISE_CHK when sync_in=1; HIGH->FALL_CHK when sync_in=0; the stability counter clears on entry.
REQ-016 In RISE_CHK/FALL_CHK, sync_in returning to the current level SHALL go back to LOW/HIGH respectively and clear the counter.
REQ-017 RISE_CHK->HIGH and FALL_CHK->LOW SHALL occur on the edge at which sync_in has differed from level for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 The stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
REQ-019 For btn_in changing and then held stable, level SHALL change on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge after the change.
REQ-020 rise_evt SHALL be the cycle in which RISE_CHK->HIGH is taken; falling transitions SHALL produce no event.
REQ-021 trig_pulse SHALL be registered and SHALL assert for exactly one cycle, on the same edge at which level rises, if and only if rise_evt=1, enable=1 and busy=0.
REQ-022 SHALL implement a holdoff FSM: IDLE (busy=0) and HOLD (busy=1).
REQ-023 IDLE->HOLD on the edge at which trig_pulse asserts; busy SHALL stay high for exactly HOLDOFF_CYCLES cycles, then return to IDLE.
REQ-024 rise_evt with busy=1 SHALL not assert trig_pulse, SHALL not extend HOLD, and SHALL increment drop_count.
REQ-025 rise_evt with enable=0 and busy=0 SHALL have no effect besides level; no count SHALL change.
REQ-026 trig_count SHALL increment by 1 per trig_pulse, wrapping 255->0.
REQ-027 drop_count SHALL saturate at 255.
REQ-028 In the cycle HOLD expires, a simultaneous rise_evt SHALL be treated as busy=1, i.e. dropped.
REQ-029 enable SHALL be sampled only at rise_evt; deasserting enable during HOLD SHALL not cut HOLD short.

Reset
REQ-030 With rst=1 at a rising edge, synchronizer flops, debounce FSM (LOW), stability counter, holdoff FSM (IDLE) and holdoff counter SHALL clear to 0.
REQ-031 level, trig_pulse, busy, trig_count and drop_count SHALL be 0 on the edge following rst sampled high and SHALL stay 0 while rst=1.
REQ-032 A btn_in held high through reset release SHALL be re-debounced from LOW and produce one trig_pulse SYNC_STAGES+DEBOUNCE_CYCLES edges after release if enable=1.

Verification (defaults unless stated)
REQ-033 SHALL cover reset: rst=1 for 3 cycles with btn_in toggling -> all outputs 0 throughout.
REQ-034 SHALL cover a clean press: btn_in 0->1 held 100 cycles, enable=1 -> level and trig_pulse rise at edge 18; busy is high for 32 cycles; trig_count=1, drop_count=0.
REQ-035 SHALL cover bounce: btn_in toggles every 5 cycles for 60 cycles then held 1 -> no trig_pulse during bounce; exactly one trig_pulse 18 edges after final settle.
REQ-036 SHALL cover retrigger in holdoff: HOLDOFF_CYCLES=100, press, release after 30 cycles, press again 30 cycles later -> one trig_pulse only, drop_count=1, trig_count=1.
REQ-037 SHALL cover enable=0: press held 50 cycles -> level rises at edge 18, trig_pulse and busy stay 0, counts unchanged.
REQ-038 SHALL cover reset mid-holdoff and count wrap: rst at busy cycle 10 with btn_in held 1 -> outputs 0, then a new trig_pulse 18 edges after release; 256 accepted presses -> trig_count=0.
